// File: rtl/operand_stack.sv
// operand_stack: WebAssembly operand stack for the cpu core.
// TOS and NOS sit in dedicated registers so the ALU reads them with no array
// access. Entries below them live in a small array indexed from the bottom.
// Any illegal operation sets a sticky trap code and freezes the stack.
// Assumes DEPTH_LOG2 >= 2, so the deep array holds at least two entries.
module operand_stack #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            op,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      top,
  output logic [WIDTH-1:0]      next,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  ready,
  output logic [3:0]            trap
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_DROP   = 3'b010,
    OP_UNARY  = 3'b011,
    OP_BINARY = 3'b100,
    OP_DROP2  = 3'b101
  } op_e;

  typedef enum logic [3:0] {
    TRAP_NONE      = 4'd0,
    TRAP_OVERFLOW  = 4'd1,
    TRAP_UNDERFLOW = 4'd2,
    TRAP_ILLEGAL   = 4'd3
  } trap_e;

  logic [WIDTH-1:0]      top_r, next_r, top_nx, next_nx;
  logic [AW-1:0]         depth_r, depth_nx;
  trap_e                 trap_r, trap_nx;

  logic [WIDTH-1:0]      mem [DEPTH-2];
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx, rd3_idx, rd4_idx;
  logic [WIDTH-1:0]      below3, below4;

  // Indices of stack elements depth-2 (push spill), depth-3 and depth-4 (refill).
  assign wr_idx  = DEPTH_LOG2'(depth_r - AW'(2));
  assign rd3_idx = DEPTH_LOG2'(depth_r - AW'(3));
  assign rd4_idx = DEPTH_LOG2'(depth_r - AW'(4));

  // Array reads are masked to 0 when the index lies below the bottom of the stack.
  assign below3 = (depth_r >= AW'(3)) ? mem[rd3_idx] : '0;
  assign below4 = (depth_r >= AW'(4)) ? mem[rd4_idx] : '0;

  // Decode the op against the current depth and compute the next stack state.
  always_comb begin
    top_nx   = top_r;
    next_nx  = next_r;
    depth_nx = depth_r;
    trap_nx  = trap_r;
    wr_en    = 1'b0;
    if (trap_r == TRAP_NONE) begin
      case (op)
        OP_NOP: ;
        OP_PUSH: begin
          if (depth_r == AW'(DEPTH)) begin
            trap_nx = TRAP_OVERFLOW;
          end else begin
            wr_en    = (depth_r >= AW'(2));
            next_nx  = top_r;
            top_nx   = data_in;
            depth_nx = depth_r + AW'(1);
          end
        end
        OP_DROP: begin
          if (depth_r < AW'(1)) begin
            trap_nx = TRAP_UNDERFLOW;
          end else begin
            top_nx   = next_r;
            next_nx  = below3;
            depth_nx = depth_r - AW'(1);
          end
        end
        OP_UNARY: begin
          if (depth_r < AW'(1)) trap_nx = TRAP_UNDERFLOW;
          else                  top_nx  = data_in;
        end
        OP_BINARY: begin
          if (depth_r < AW'(2)) begin
            trap_nx = TRAP_UNDERFLOW;
          end else begin
            top_nx   = data_in;
            next_nx  = below3;
            depth_nx = depth_r - AW'(1);
          end
        end
        OP_DROP2: begin
          if (depth_r < AW'(2)) begin
            trap_nx = TRAP_UNDERFLOW;
          end else begin
            top_nx   = below3;
            next_nx  = below4;
            depth_nx = depth_r - AW'(2);
          end
        end
        default: trap_nx = TRAP_ILLEGAL;
      endcase
    end
  end

  // State registers for TOS, NOS, depth and the sticky trap.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_r   <= '0;
      next_r  <= '0;
      depth_r <= '0;
      trap_r  <= TRAP_NONE;
    end else begin
      top_r   <= top_nx;
      next_r  <= next_nx;
      depth_r <= depth_nx;
      trap_r  <= trap_nx;
    end
  end

  // Spill the old NOS into the deep array on a push.
  // NOTE: the array has no reset; entries are only read below a valid depth, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= next_r;
  end

  assign top   = top_r;
  assign next  = next_r;
  assign depth = depth_r;
  assign empty = (depth_r == '0);
  assign full  = (depth_r == AW'(DEPTH));
  assign ready = (trap_r == TRAP_NONE);
  assign trap  = trap_r;

endmodule

// File: doc/operand_stack.md
# operand_stack

Operand value stack for the `cpu` core: holds the WebAssembly operand stack, presents the two topmost entries combinationally to the ALU, and applies push/pop/replace operations issued by the decode stage in a single cycle. It sits between decode/ALU and the `result`/`result_empty` outputs, which are driven directly from its `top` and `empty` ports. Stack overflow, underflow and illegal operations raise a sticky trap code that the core forwards on its `trap` port.

## Interface

- `WIDTH`, 64, entry width in bits (i32 values zero-extended by the ALU).
- `DEPTH_LOG2`, 4, log2 of capacity; `DEPTH = 2**DEPTH_LOG2`; minimum 2.

- `clk`  in  1  clock, all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `op`  in  3  operation code, sampled every rising edge.
- `data_in`  in  WIDTH  value for PUSH / UNARY / BINARY.
- `top`  out  WIDTH  top of stack (TOS); 0 when `depth == 0`.
- `next`  out  WIDTH  second entry (NOS); 0 when `depth < 2`.
- `depth`  out  DEPTH_LOG2+1  number of valid entries.
- `empty`  out  1  `depth == 0`.
- `full`  out  1  `depth == DEPTH`.
- `ready`  out  1  `trap == 0`; ops are accepted only while high.
- `trap`  out  4  sticky trap code: 0 none, 1 overflow, 2 underflow, 3 illegal op.

## Operation

- Storage: registers `top_r`, `next_r` plus a `DEPTH-2` entry array for deeper entries (entry index `i` holds stack element `i`, 0 = bottom); array needs two asynchronous read ports (indices `depth-3`, `depth-4`) and one write port.
- Op codes (required depth / resulting depth change):
  - 000 NOP: no change.
  - 001 PUSH (`depth < DEPTH`, +1): array[depth-2] <= next_r if depth ≥ 2; next_r <= top_r; top_r <= data_in.
  - 010 DROP (≥1, −1): top_r <= next_r; next_r <= array[depth-3] (0 if depth < 3).
  - 011 UNARY (≥1, 0): top_r <= data_in.
  - 100 BINARY (≥2, −1): top_r <= data_in; next_r <= array[depth-3] (0 if depth < 3). ALU computes `data_in` from `next` (lhs) and `top` (rhs) combinationally in the same cycle.
  - 101 DROP2 (≥2, −2): top_r <= array[depth-3]; next_r <= array[depth-4] (0 when index < 0).
  - 110, 111: illegal.
- Violations: PUSH at full -> trap 1; any op below required depth -> trap 2; illegal code -> trap 3. On violation stack contents and depth stay unchanged.
- Trap is sticky: while `trap != 0` all ops, including NOP, are ignored; only `reset` clears it. First violation wins.
- Zeroing rule: vacated `top_r`/`next_r` positions load 0 so `top`/`next` read 0 below their valid depth.
- Depth arithmetic unsigned, DEPTH_LOG2+1 bits; never wraps (guarded by the checks above).

## Timing

- Reset values: `top`=0, `next`=0, `depth`=0, `empty`=1, `full`=0, `ready`=1, `trap`=0. Asserting `reset` mid-sequence clears state asynchronously; first op accepted is on the first rising edge after deassertion.
- All outputs registered-state derived; effect of an op at edge N visible after edge N, stable for the cycle following.
- Throughput one op per cycle, no stalls; back-to-back ops use the post-edge state of the previous op.
- `trap` and `ready` update on the same edge as the offending op.
- BINARY at full is legal (depth decreases); PUSH at `DEPTH-1` is legal and sets `full`.

## Test plan

- Reset: hold `reset` 2 cycles -> `top`=0, `depth`=0, `empty`=1, `trap`=0, `ready`=1.
- i32.ne pattern: PUSH 5, PUSH 5, BINARY with `data_in`=0 (ALU ne result) -> after 3rd edge `top`=0, `depth`=1, `empty`=0, `trap`=0; during BINARY cycle `next`=5, `top`=5.
- Deep shuffle (`DEPTH_LOG2`=4): PUSH 1..6, DROP2, DROP -> `top`=3, `next`=2, `depth`=3; then BINARY `data_in`=9 -> `top`=9, `next`=1, `depth`=2.
- Overflow: 16 PUSHes (`full`=1, `trap`=0), 17th PUSH 0xAA -> `trap`=1, `ready`=0, `depth`=16, `top`=value of 16th push; subsequent DROP ignored.
- Underflow/illegal: from reset, BINARY -> `trap`=2, `depth`=0; after reset, op 110 -> `trap`=3; further PUSH ignored until reset.
- Reset mid-run: PUSH 7, PUSH 8, assert `reset` between edges -> `depth`=0, `top`=0 immediately without a clock edge.
